// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg
// Shared state encoding and sizing helper for the Segway power-up reset
// sequencer (rst_sequencer) and its delay counter (rst_seq_cnt).
package rst_seq_pkg;

   typedef enum logic [2:0] {
      HOLD  = 3'd0,
      WAIT  = 3'd1,
      DWELL = 3'd2,
      RUN   = 3'd3,
      FAULT = 3'd4,
      SOFT  = 3'd5
   } rseq_state_t;

   // Width of a stage index. Never narrower than one bit so that a
   // single-stage build still has a legal fault_stage port.
   function automatic int idxWidth(input int numStages);
      return (numStages > 1) ? $clog2(numStages) : 1;
   endfunction

endpackage

// File: rtl/rst_seq_cnt.sv
// rst_seq_cnt
// Cycle counter used by the reset sequencer for hold, dwell and timeout
// intervals. Synchronous clear has priority over enable; the count
// saturates instead of wrapping.
// Ports:
//   clk    in   system clock
//   RST_n  in   asynchronous active-low clear
//   clr_i  in   synchronous clear to zero
//   en_i   in   count enable
//   cnt_o  out  current count
module rst_seq_cnt
   import rst_seq_pkg::*;
#(
   parameter int DLY_W = 16
) (
   input  logic             clk,
   input  logic             RST_n,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [DLY_W-1:0] cnt_o
);

   logic [DLY_W-1:0] cnt_q;
   logic [DLY_W-1:0] cnt_d;

   // Next count: clear wins, otherwise step when enabled and not at the top.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + DLY_W'(1);
      end
   end

   // Count register, cleared straight away by the raw reset.
   always_ff @(posedge clk or negedge RST_n) begin
      if (!RST_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/rst_sequencer.sv
// rst_sequencer
// Power-up reset controller for the Segway top level. Synchronizes the raw
// push-button reset and releases the per-subsystem resets one at a time,
// waiting for each stage to report ready and then dwelling before the next.
// Readiness is supervised; a timeout or a lost ready latches a sticky fault
// that only a soft reset request or RST_n clears.
// Ports:
//   clk           in   system clock
//   RST_n         in   raw asynchronous active-low reset
//   soft_rst_req  in   soft reset request, rising edge honored
//   stage_rdy     in   per-stage ready (meaningful only while that stage is released)
//   rst_n_out     out  per-stage active-low resets, stage 0 released first
//   sys_rdy       out  every stage released and ready
//   seq_fault     out  sticky sequencing/readiness fault
//   fault_stage   out  index of the stage that caused the fault
module rst_sequencer
   import rst_seq_pkg::*;
#(
   parameter  int NUM_STAGES = 3,
   parameter  int DLY_W      = 16,
   parameter  int HOLD_CYC   = 1024,
   parameter  int STAGE_DLY  = 256,
   parameter  int TIMEOUT    = 50000,
   localparam int IDX_W      = idxWidth(NUM_STAGES)
) (
   input  logic                  clk,
   input  logic                  RST_n,
   input  logic                  soft_rst_req,
   input  logic [NUM_STAGES-1:0] stage_rdy,
   output logic [NUM_STAGES-1:0] rst_n_out,
   output logic                  sys_rdy,
   output logic                  seq_fault,
   output logic [IDX_W-1:0]      fault_stage
);

   if ((NUM_STAGES < 1) ||
       (HOLD_CYC  < 1) || (HOLD_CYC  >= (1 << DLY_W)) ||
       (STAGE_DLY < 1) || (STAGE_DLY >= (1 << DLY_W)) ||
       (TIMEOUT   < 1) || (TIMEOUT   >= (1 << DLY_W))) begin : gParamCheck
      $error("rst_sequencer: cycle parameter out of range for DLY_W");
   end

   localparam logic [DLY_W-1:0] HOLD_LAST    = DLY_W'(HOLD_CYC - 1);
   localparam logic [DLY_W-1:0] DWELL_LAST   = DLY_W'(STAGE_DLY - 1);
   localparam logic [DLY_W-1:0] TIMEOUT_LAST = DLY_W'(TIMEOUT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_STAGES - 1);

   logic                  syncMeta_q;
   logic                  rstSync_q;
   logic                  softReq_q;
   logic                  softReqPrev_q;
   logic                  softEdge;
   rseq_state_t           state_q;
   rseq_state_t           state_d;
   logic [IDX_W-1:0]      idx_q;
   logic [IDX_W-1:0]      idx_d;
   logic [NUM_STAGES-1:0] rstNOut_q;
   logic [NUM_STAGES-1:0] rstNOut_d;
   logic                  sysRdy_q;
   logic                  sysRdy_d;
   logic                  seqFault_q;
   logic                  seqFault_d;
   logic [IDX_W-1:0]      faultStage_q;
   logic [IDX_W-1:0]      faultStage_d;
   logic [NUM_STAGES-1:0] dropped;
   logic [IDX_W-1:0]      lowDrop;
   logic                  cntClr;
   logic                  cntEn;
   logic [DLY_W-1:0]      cnt;

   // Reset release synchronizer. It runs on the falling edge so the FSM
   // sees a clean level half a cycle later; assertion stays asynchronous.
   always_ff @(negedge clk or negedge RST_n) begin
      if (!RST_n) begin
         syncMeta_q <= 1'b0;
         rstSync_q  <= 1'b0;
      end else begin
         syncMeta_q <= 1'b1;
         rstSync_q  <= syncMeta_q;
      end
   end

   // Soft request is registered first, then edge-detected, so a level
   // held high produces exactly one restart.
   always_ff @(posedge clk or negedge RST_n) begin
      if (!RST_n) begin
         softReq_q     <= 1'b0;
         softReqPrev_q <= 1'b0;
      end else begin
         softReq_q     <= soft_rst_req;
         softReqPrev_q <= softReq_q;
      end
   end

   assign softEdge = softReq_q & ~softReqPrev_q;

   // Only stages already released can lose their ready.
   assign dropped = rstNOut_q & ~stage_rdy;

   // Lowest dropped stage index; the descending scan lets lower indices win.
   always_comb begin
      lowDrop = '0;
      for (int j = NUM_STAGES - 1; j >= 0; j--) begin
         if (dropped[j]) begin
            lowDrop = IDX_W'(j);
         end
      end
   end

   // Next state and next registered outputs. Fault entry forces every reset
   // low, and a soft edge outside HOLD overrides whatever else was decided.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      rstNOut_d    = rstNOut_q;
      sysRdy_d     = sysRdy_q;
      seqFault_d   = seqFault_q;
      faultStage_d = faultStage_q;
      cntEn        = 1'b0;

      case (state_q)
         HOLD: begin
            if (rstSync_q) begin
               cntEn = 1'b1;
               if (cnt == HOLD_LAST) begin
                  rstNOut_d[0] = 1'b1;
                  idx_d        = '0;
                  state_d      = WAIT;
               end
            end
         end
         WAIT: begin
            cntEn = 1'b1;
            if (stage_rdy[idx_q]) begin
               state_d = DWELL;
            end else if (cnt == TIMEOUT_LAST) begin
               state_d      = FAULT;
               faultStage_d = idx_q;
            end
         end
         DWELL: begin
            cntEn = 1'b1;
            if (|dropped) begin
               state_d      = FAULT;
               faultStage_d = lowDrop;
            end else if (cnt == DWELL_LAST) begin
               if (idx_q == LAST_IDX) begin
                  state_d  = RUN;
                  sysRdy_d = 1'b1;
               end else begin
                  idx_d            = idx_q + IDX_W'(1);
                  rstNOut_d[idx_d] = 1'b1;
                  state_d          = WAIT;
               end
            end
         end
         RUN: begin
            if (|dropped) begin
               state_d      = FAULT;
               faultStage_d = lowDrop;
            end
         end
         FAULT: begin
            state_d = FAULT;
         end
         SOFT: begin
            state_d = HOLD;
         end
         default: begin
            state_d = HOLD;
         end
      endcase

      if (state_d == FAULT) begin
         rstNOut_d  = '0;
         sysRdy_d   = 1'b0;
         seqFault_d = 1'b1;
      end

      if (softEdge && (state_q != HOLD)) begin
         state_d      = SOFT;
         idx_d        = '0;
         rstNOut_d    = '0;
         sysRdy_d     = 1'b0;
         seqFault_d   = 1'b0;
         faultStage_d = '0;
      end
   end

   // Every state entry restarts the interval count; SOFT holds it at zero.
   assign cntClr = (state_d != state_q) || (state_q == SOFT);

   rst_seq_cnt #(
      .DLY_W (DLY_W)
   ) uCnt (
      .clk   (clk),
      .RST_n (RST_n),
      .clr_i (cntClr),
      .en_i  (cntEn),
      .cnt_o (cnt)
   );

   // State and output registers. Assertion of the resets is asynchronous;
   // release only ever happens through this clocked path.
   always_ff @(posedge clk or negedge RST_n) begin
      if (!RST_n) begin
         state_q      <= HOLD;
         idx_q        <= '0;
         rstNOut_q    <= '0;
         sysRdy_q     <= 1'b0;
         seqFault_q   <= 1'b0;
         faultStage_q <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         rstNOut_q    <= rstNOut_d;
         sysRdy_q     <= sysRdy_d;
         seqFault_q   <= seqFault_d;
         faultStage_q <= faultStage_d;
      end
   end

   assign rst_n_out   = rstNOut_q;
   assign sys_rdy     = sysRdy_q;
   assign seq_fault   = seqFault_q;
   assign fault_stage = faultStage_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer
// Self-checking bench for rst_sequencer. Each stage's ready is modelled as
// "rst_n_out[k] has been high for at least dly[k] cycles", with randomized
// delays. Expected event cycles come from the sequencing rules: hold after
// sync, wait for ready, dwell, release the next stage.
module tb_rst_sequencer;

   localparam int NUM_STAGES = 3;
   localparam int DLY_W      = 16;
   localparam int HOLD_CYC   = 8;
   localparam int STAGE_DLY  = 4;
   localparam int TIMEOUT    = 20;
   localparam int BUDGET     = 400;

   logic                  clk          = 1'b0;
   logic                  RST_n        = 1'b0;
   logic                  soft_rst_req = 1'b0;
   logic [NUM_STAGES-1:0] stage_rdy;
   logic [NUM_STAGES-1:0] rst_n_out;
   logic                  sys_rdy;
   logic                  seq_fault;
   logic [1:0]            fault_stage;

   int                    cyc = 0;
   int                    dly [NUM_STAGES];
   int                    hiCnt [NUM_STAGES];
   logic [NUM_STAGES-1:0] stuck = '0;
   logic [NUM_STAGES-1:0] drop  = '0;
   int                    checkCount = 0;
   int                    passCount  = 0;
   int                    rise0Cnt   = 0;
   logic                  prev0      = 1'b0;

   rst_sequencer #(
      .NUM_STAGES (NUM_STAGES),
      .DLY_W      (DLY_W),
      .HOLD_CYC   (HOLD_CYC),
      .STAGE_DLY  (STAGE_DLY),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk          (clk),
      .RST_n        (RST_n),
      .soft_rst_req (soft_rst_req),
      .stage_rdy    (stage_rdy),
      .rst_n_out    (rst_n_out),
      .sys_rdy      (sys_rdy),
      .seq_fault    (seq_fault),
      .fault_stage  (fault_stage)
   );

   always #5 clk = ~clk;

   // Posedge counter used to timestamp events.
   always @(posedge clk) cyc <= cyc + 1;

   // How long each stage has been out of reset.
   always @(posedge clk) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
         hiCnt[k] <= rst_n_out[k] ? hiCnt[k] + 1 : 0;
      end
   end

   // Stage ready model with stuck-low and one-shot drop overrides.
   always_comb begin
      stage_rdy = '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
         stage_rdy[k] = (hiCnt[k] >= dly[k]) && !stuck[k] && !drop[k];
      end
   end

   // Counts releases of stage 0 to detect repeated restarts.
   always @(negedge clk) begin
      prev0 <= rst_n_out[0];
      if (rst_n_out[0] && !prev0) rise0Cnt <= rise0Cnt + 1;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   function automatic logic sigSel(input int sel);
      logic v;
      case (sel)
         0:       v = rst_n_out[0];
         1:       v = rst_n_out[1];
         2:       v = rst_n_out[2];
         3:       v = sys_rdy;
         default: v = seq_fault;
      endcase
      return v;
   endfunction

   function automatic int lowestSet(input logic [NUM_STAGES-1:0] m);
      int low;
      low = 0;
      for (int k = NUM_STAGES - 1; k >= 0; k--) begin
         if (m[k]) low = k;
      end
      return low;
   endfunction

   // Waits for a 0->1 transition seen on falling edges; -1 if none in budget.
   task automatic waitRise(input int sel, output int at);
      logic prev;
      logic cur;
      at   = -1;
      prev = sigSel(sel);
      for (int n = 0; (n < BUDGET) && (at < 0); n++) begin
         @(negedge clk);
         cur = sigSel(sel);
         if (cur && !prev) at = cyc;
         prev = cur;
      end
   endtask

   // Asserts RST_n, then releases it just after a rising edge.
   task automatic applyStimulus(output int relCyc);
      @(posedge clk);
      #2 RST_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 RST_n = 1'b1;
      relCyc = cyc;
   endtask

   // Follows one full release sequence from the expected stage-0 release.
   task automatic runSequence(input string tag, input int expR0);
      int expCyc;
      int seen;
      expCyc = expR0;
      for (int k = 0; k < NUM_STAGES; k++) begin
         waitRise(k, seen);
         checkOutput($sformatf("%s rise%0d", tag, k), seen, expCyc);
         expCyc = expCyc + dly[k] + 1 + STAGE_DLY;
      end
      waitRise(3, seen);
      checkOutput($sformatf("%s sysRdy", tag), seen, expCyc);
      checkOutput($sformatf("%s seqFault", tag), 32'(seq_fault), 32'd0);
   endtask

   initial begin
      int relCyc;
      int seen;
      int expR1;
      int expS;
      int softCyc;
      int base;
      int guard;
      logic [NUM_STAGES-1:0] m;

      for (int k = 0; k < NUM_STAGES; k++) dly[k] = 3;

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset rstOut", 32'(rst_n_out), 32'd0);
      checkOutput("reset sysRdy", 32'(sys_rdy), 32'd0);
      checkOutput("reset seqFault", 32'(seq_fault), 32'd0);
      checkOutput("reset faultStage", 32'(fault_stage), 32'd0);

      for (int it = 0; it < 3; it++) begin
         for (int k = 0; k < NUM_STAGES; k++) dly[k] = int'($urandom_range(1, 8));
         applyStimulus(relCyc);
         runSequence("pwr", relCyc + 1 + HOLD_CYC);
         checkOutput("pwr rstOut", 32'(rst_n_out), 32'd7);

         m = NUM_STAGES'($urandom_range(1, 7));
         @(posedge clk);
         #1 drop = m;
         @(posedge clk);
         #1 drop = '0;
         @(negedge clk);
         checkOutput("loss seqFault", 32'(seq_fault), 32'd1);
         checkOutput("loss faultStage", 32'(fault_stage), 32'(lowestSet(m)));
         checkOutput("loss sysRdy", 32'(sys_rdy), 32'd0);
         checkOutput("loss rstOut", 32'(rst_n_out), 32'd0);
         repeat (10) @(negedge clk);
         checkOutput("loss sticky", 32'(seq_fault), 32'd1);

         @(posedge clk);
         #1 soft_rst_req = 1'b1;
         softCyc = cyc;
         @(posedge clk);
         #1 soft_rst_req = 1'b0;
         @(posedge clk);
         @(negedge clk);
         checkOutput("soft seqFault", 32'(seq_fault), 32'd0);
         checkOutput("soft faultStage", 32'(fault_stage), 32'd0);
         runSequence("soft", softCyc + 3 + HOLD_CYC);
      end

      // Stage 1 never ready: timeout measured from its release.
      for (int k = 0; k < NUM_STAGES; k++) dly[k] = int'($urandom_range(1, 8));
      stuck = 3'b010;
      applyStimulus(relCyc);
      waitRise(0, seen);
      checkOutput("tmo rise0", seen, relCyc + 1 + HOLD_CYC);
      expR1 = relCyc + 1 + HOLD_CYC + dly[0] + 1 + STAGE_DLY;
      waitRise(1, seen);
      checkOutput("tmo rise1", seen, expR1);
      waitRise(4, seen);
      checkOutput("tmo faultCyc", seen, expR1 + TIMEOUT);
      checkOutput("tmo faultStage", 32'(fault_stage), 32'd1);
      checkOutput("tmo rstOut", 32'(rst_n_out), 32'd0);
      @(posedge clk);
      #2 RST_n = 1'b0;
      #1;
      checkOutput("async fault seqFault", 32'(seq_fault), 32'd0);
      checkOutput("async fault faultStage", 32'(fault_stage), 32'd0);

      // Async reset in the middle of stage 1's wait, soft pulse ignored in HOLD.
      applyStimulus(relCyc);
      @(posedge clk);
      @(posedge clk);
      #1 soft_rst_req = 1'b1;
      @(posedge clk);
      #1 soft_rst_req = 1'b0;
      waitRise(0, seen);
      checkOutput("holdSoft rise0", seen, relCyc + 1 + HOLD_CYC);
      waitRise(1, seen);
      checkOutput("midWait rise1", seen, relCyc + 1 + HOLD_CYC + dly[0] + 1 + STAGE_DLY);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("midWait rstOut", 32'(rst_n_out), 32'd3);
      #1 RST_n = 1'b0;
      #1;
      checkOutput("async rstOut", 32'(rst_n_out), 32'd0);
      checkOutput("async sysRdy", 32'(sys_rdy), 32'd0);
      stuck = '0;
      @(posedge clk);
      #1 RST_n = 1'b1;
      relCyc = cyc;
      runSequence("rerun", relCyc + 1 + HOLD_CYC);

      // Ready arriving on the last timeout cycle wins; one cycle later faults.
      dly[0] = TIMEOUT - 1;
      dly[1] = int'($urandom_range(1, 8));
      dly[2] = int'($urandom_range(1, 8));
      applyStimulus(relCyc);
      runSequence("rdyEdge", relCyc + 1 + HOLD_CYC);
      dly[0] = TIMEOUT;
      applyStimulus(relCyc);
      waitRise(0, seen);
      checkOutput("late rise0", seen, relCyc + 1 + HOLD_CYC);
      waitRise(4, seen);
      checkOutput("late faultCyc", seen, relCyc + 1 + HOLD_CYC + TIMEOUT);
      checkOutput("late faultStage", 32'(fault_stage), 32'd0);

      // Soft edge lands on the RUN entry edge.
      for (int k = 0; k < NUM_STAGES; k++) dly[k] = int'($urandom_range(1, 8));
      applyStimulus(relCyc);
      expS = relCyc + 1 + HOLD_CYC;
      for (int k = 0; k < NUM_STAGES; k++) expS = expS + dly[k] + 1 + STAGE_DLY;
      guard = 0;
      while ((cyc < expS - 2) && (guard < BUDGET)) begin
         @(posedge clk);
         #1;
         guard++;
      end
      soft_rst_req = 1'b1;
      softCyc = cyc;
      @(posedge clk);
      #1 soft_rst_req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("softWin sysRdy", 32'(sys_rdy), 32'd0);
      checkOutput("softWin rstOut", 32'(rst_n_out), 32'd0);
      runSequence("softWin", softCyc + 3 + HOLD_CYC);

      // Level held high for 100 cycles restarts exactly once.
      @(posedge clk);
      #1;
      base = rise0Cnt;
      soft_rst_req = 1'b1;
      softCyc = cyc;
      runSequence("hold", softCyc + 3 + HOLD_CYC);
      guard = 0;
      while ((cyc < softCyc + 100) && (guard < BUDGET)) begin
         @(posedge clk);
         #1;
         guard++;
      end
      checkOutput("hold restarts", rise0Cnt - base, 32'd1);
      checkOutput("hold sysRdy", 32'(sys_rdy), 32'd1);
      soft_rst_req = 1'b0;

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
